pmem_arbiter: RTL and testbench

- Two-client arbiter between the I-cache and D-cache control units and the single physical memory port.
- Each cache issues line-sized read/write requests (pmem_read/pmem_write, line-aligned address, 128-bit line) and holds them until it sees its resp.
- The arbiter picks one client and registers its request onto the memory port. It returns the memory response to that client only.
- Ties are resolved round-robin, so back-to-back two-line fills from one cache cannot starve the other.

---
 rtl/pmem_arbiter.sv | 139 +++++++++++++
 tb/tb_pmem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
`default_nettype none
// =============================================================================
// pmem_arbiter - round-robin arbiter between I-cache and D-cache for one pmem port
// Optional macro PMEM_ARB_STATS_EN adds grant/conflict counters.  Revision: 1.0
// =============================================================================
module pmem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128,
   parameter bit D_FIRST    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_pmem_read,
   input  logic                  i_pmem_write,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
`ifdef PMEM_ARB_STATS_EN
   ,
   output logic [15:0]           stat_i_grants,
   output logic [15:0]           stat_d_grants,
   output logic [15:0]           stat_conflicts
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_i_req;
   logic                  w_d_req;
   logic                  w_grant_i;
   logic                  w_grant_d;
   logic                  r_last_d;    // 1 when D-cache held the most recent grant
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;

   assign w_i_req = i_pmem_read | i_pmem_write;
   assign w_d_req = d_pmem_read | d_pmem_write;

   always_comb begin
      w_next    = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_i_req && (!w_d_req || r_last_d)) begin
               w_grant_i = 1'b1;
               w_next    = BUSY_I;
            end else if (w_d_req) begin
               w_grant_d = 1'b1;
               w_next    = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (pmem_resp) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_last_d <= ~D_FIRST;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant_i) begin
            r_last_d <= 1'b0;
            r_we     <= i_pmem_write;
            r_addr   <= i_pmem_address;
            r_wdata  <= i_pmem_wdata;
         end else if (w_grant_d) begin
            r_last_d <= 1'b1;
            r_we     <= d_pmem_write;
            r_addr   <= d_pmem_address;
            r_wdata  <= d_pmem_wdata;
         end
      end
   end

   // Strobes derive from state so an asynchronous reset drops them at once.
   assign pmem_read    = (r_state != IDLE) && !r_we;
   assign pmem_write   = (r_state != IDLE) &&  r_we;
   assign pmem_address = r_addr;
   assign pmem_wdata   = r_wdata;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   assign i_pmem_resp  = (r_state == BUSY_I) && pmem_resp;
   assign d_pmem_resp  = (r_state == BUSY_D) && pmem_resp;

`ifdef PMEM_ARB_STATS_EN
   logic [15:0] r_stat_i;
   logic [15:0] r_stat_d;
   logic [15:0] r_stat_c;
   logic        w_conflict;

   assign w_conflict = (r_state == IDLE) && w_i_req && w_d_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_i <= '0;
         r_stat_d <= '0;
         r_stat_c <= '0;
      end else begin
         if (w_grant_i && (r_stat_i != 16'hFFFF)) r_stat_i <= r_stat_i + 16'd1;
         if (w_grant_d && (r_stat_d != 16'hFFFF)) r_stat_d <= r_stat_d + 16'd1;
         if (w_conflict && (r_stat_c != 16'hFFFF)) r_stat_c <= r_stat_c + 16'd1;
      end
   end

   assign stat_i_grants  = r_stat_i;
   assign stat_d_grants  = r_stat_d;
   assign stat_conflicts = r_stat_c;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_pmem_arbiter - directed vector bench for pmem_arbiter
// Revision: 1.0
// =============================================================================
module tb_pmem_arbiter;

   localparam logic [127:0] C_RD  = {8{16'hA5A5}};
   localparam logic [127:0] C_DWD = {8{16'h1234}};
   localparam logic [127:0] C_IWD = {8{16'h5A5A}};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_rd, i_wr, d_rd, d_wr;
   logic [15:0]  i_addr, d_addr;
   logic [127:0] i_rdata, d_rdata;
   logic         i_resp, d_resp;
   logic         p_rd, p_wr, p_resp;
   logic [15:0]  p_addr;
   logic [127:0] p_wdata;
   logic [127:0] p_rdata;
`ifdef PMEM_ARB_STATS_EN
   logic [15:0]  st_i, st_d, st_c;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pmem_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_pmem_read    (i_rd),
      .i_pmem_write   (i_wr),
      .i_pmem_address (i_addr),
      .i_pmem_wdata   (C_IWD),
      .i_pmem_rdata   (i_rdata),
      .i_pmem_resp    (i_resp),
      .d_pmem_read    (d_rd),
      .d_pmem_write   (d_wr),
      .d_pmem_address (d_addr),
      .d_pmem_wdata   (C_DWD),
      .d_pmem_rdata   (d_rdata),
      .d_pmem_resp    (d_resp),
      .pmem_read      (p_rd),
      .pmem_write     (p_wr),
      .pmem_address   (p_addr),
      .pmem_wdata     (p_wdata),
      .pmem_rdata     (p_rdata),
      .pmem_resp      (p_resp)
`ifdef PMEM_ARB_STATS_EN
      ,
      .stat_i_grants  (st_i),
      .stat_d_grants  (st_d),
      .stat_conflicts (st_c)
`endif
   );

   typedef struct {
      logic        ir, iw;
      logic [15:0] ia;
      logic        dr, dw;
      logic [15:0] da;
      logic        pr;
      logic        er, ew;
      logic [15:0] ea;
      logic        eir, edr;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic ir, logic iw, logic [15:0] ia,
                               logic dr, logic dw, logic [15:0] da, logic pr,
                               logic er, logic ew, logic [15:0] ea,
                               logic eir, logic edr);
      vec_t v;
      v.ir = ir; v.iw = iw; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.pr = pr;
      v.er = er; v.ew = ew; v.ea = ea; v.eir = eir; v.edr = edr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // strobes {rd,wr} and resps {i,d} packed together for compact checks
   function automatic logic [127:0] obs();
      return {124'd0, p_rd, p_wr, i_resp, d_resp};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; i_rd = 0; i_wr = 0; d_rd = 0; d_wr = 0;
      i_addr = '0; d_addr = '0; p_rdata = C_RD; p_resp = 1'b1;

      //           ir iw ia       dr dw da       pr  er ew ea       ei ed
      tv.push_back(mk(1,0,16'h0040, 0,1,16'h8000, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0040, 0,1,16'h8000, 0,  0,1,16'h8000, 0,0));
      tv.push_back(mk(1,0,16'h0040, 0,1,16'h8000, 1,  0,1,16'h8000, 0,1));
      tv.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 1,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 0,  1,0,16'h0040, 0,0));
      tv.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 1,  1,0,16'h0040, 1,0));
      tv.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h1230, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h1230, 0,0,16'h0000, 0,  1,0,16'h1230, 0,0));
      tv.push_back(mk(1,0,16'hFFFF, 0,0,16'h0000, 0,  1,0,16'h1230, 0,0));
      tv.push_back(mk(1,0,16'h1230, 0,0,16'h0000, 1,  1,0,16'h1230, 1,0));
      tv.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 1,  1,0,16'h0200, 0,1));
      tv.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 1,  1,0,16'h0100, 1,0));
      tv.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 1,  1,0,16'h0200, 0,1));
      tv.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0100, 1,0,16'h0200, 1,  1,0,16'h0100, 1,0));
      tv.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(0,0,16'h0000, 1,0,16'h2000, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0300, 1,0,16'h2000, 0,  1,0,16'h2000, 0,0));
      tv.push_back(mk(1,0,16'h0300, 1,0,16'h2000, 1,  1,0,16'h2000, 0,1));
      tv.push_back(mk(1,0,16'h0300, 1,0,16'h2010, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(1,0,16'h0300, 1,0,16'h2010, 1,  1,0,16'h0300, 1,0));
      tv.push_back(mk(0,0,16'h0000, 1,0,16'h2010, 0,  0,0,16'h0000, 0,0));
      tv.push_back(mk(0,0,16'h0000, 1,0,16'h2010, 1,  1,0,16'h2010, 0,1));
      tv.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0));

      // reset state, with a spurious pmem_resp held high
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes_resp", obs(), 128'd0);
      chk("rst_addr", {112'd0, p_addr}, 128'd0);
      chk("rst_wdata", p_wdata, 128'd0);
      chk("i_rdata_wire", i_rdata, C_RD);
      chk("d_rdata_wire", d_rdata, C_RD);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      p_resp = 1'b0;

      for (int k = 0; k < tv.size(); k++) begin
         i_rd = tv[k].ir; i_wr = tv[k].iw; i_addr = tv[k].ia;
         d_rd = tv[k].dr; d_wr = tv[k].dw; d_addr = tv[k].da;
         p_resp = tv[k].pr;
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", k), obs(),
             {124'd0, tv[k].er, tv[k].ew, tv[k].eir, tv[k].edr});
         if (tv[k].er || tv[k].ew)
            chk($sformatf("vec%0d_addr", k), {112'd0, p_addr}, {112'd0, tv[k].ea});
         if (tv[k].ew)
            chk($sformatf("vec%0d_wdata", k), p_wdata, C_DWD);
         nxt();
      end
      i_rd = 0; i_wr = 0; d_rd = 0; d_wr = 0; p_resp = 0;

      // D asserts read+write (treated as write), then drops mid-transaction
      d_rd = 1; d_wr = 1; d_addr = 16'h4440;
      nxt();
      d_rd = 0; d_wr = 0;
      @(negedge clk);
      chk("rw_is_write", obs(), {124'd0, 4'b0100});
      chk("rw_addr", {112'd0, p_addr}, {112'd0, 16'h4440});
      nxt();
      p_resp = 1;
      @(negedge clk);
      chk("drop_still_resp", obs(), {124'd0, 4'b0101});
      nxt();
      p_resp = 0;
      @(negedge clk);
      chk("drop_idle", obs(), 128'd0);
      nxt();

      // asynchronous reset while BUSY_D abandons the access
      d_rd = 1; d_addr = 16'h5550;
      nxt();
      @(negedge clk);
      chk("busy_d_read", obs(), {124'd0, 4'b1000});
      #1;
      rst_n = 1'b0; p_resp = 1'b1;
      #1;
      chk("async_rst_ctl", obs(), 128'd0);
      chk("async_rst_addr", {112'd0, p_addr}, 128'd0);
      d_rd = 0; p_resp = 0;
      nxt();
      rst_n = 1'b1;
      i_rd = 1; i_addr = 16'h6660;
      nxt();
      @(negedge clk);
      chk("post_rst_grant", obs(), {124'd0, 4'b1000});
      chk("post_rst_addr", {112'd0, p_addr}, {112'd0, 16'h6660});
      nxt();
      p_resp = 1;
      @(negedge clk);
      chk("post_rst_resp", obs(), {124'd0, 4'b1010});
      nxt();
      i_rd = 0; p_resp = 0;
      nxt();

`ifdef PMEM_ARB_STATS_EN
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int s = 0; s < 5; s++) begin
         i_rd = (s == 0 || s == 1 || s == 4);
         d_rd = (s != 4);
         i_addr = 16'h0700; d_addr = 16'h0800;
         nxt();
         p_resp = 1;
         nxt();
         p_resp = 0; i_rd = 0; d_rd = 0;
      end
      nxt();
      @(negedge clk);
      chk("stat_d", {112'd0, st_d}, 128'd3);
      chk("stat_i", {112'd0, st_i}, 128'd2);
      chk("stat_c", {112'd0, st_c}, 128'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
